// File: rtl/spi_pkg.sv
// Shared SPI definitions: transfer state encoding and SCLK divider sizing.
// Used by the SPI master and the companion slave block.
package spi_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LEAD,
        S_XFER,
        S_TRAIL
    } spi_state_t;

    function automatic int half_cycles(input int clk_freq, input int spi_freq);
        return clk_freq / (2 * spi_freq);
    endfunction

endpackage

// File: rtl/spi_clk_div.sv
// SCLK half-period timer: one-cycle tick every HALF clocks while enabled.
// Held at zero while cleared so the first tick lands exactly HALF cycles in.
module spi_clk_div #(
    parameter int HALF = 5
) (
    input  logic clk,
    input  logic arstn,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tick
);

    localparam int CW = (HALF > 1) ? $clog2(HALF) : 1;

    logic [CW-1:0] r_cnt;
    logic          w_wrap;

    assign w_wrap = (r_cnt == CW'(HALF - 1));
    assign o_tick = i_en && !i_clr && w_wrap;

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/spi_master_mc.sv
// Multi-slave full-duplex SPI master with per-transfer mode, length,
// bit order and one-hot chip select.
module spi_master_mc
    import spi_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int SPI_FREQ   = 5_000_000,
    parameter int DATA_WIDTH = 8,
    parameter int NUM_CS     = 4,
    localparam int CSW = (NUM_CS > 1) ? $clog2(NUM_CS) : 1,
    localparam int LW  = $clog2(DATA_WIDTH + 1)
) (
    input  logic                  clk,
    input  logic                  arstn,
    input  logic                  start,
    input  logic [CSW-1:0]        cs_sel,
    input  logic                  cpol,
    input  logic                  cpha,
    input  logic                  lsb_first,
    input  logic [LW-1:0]         len,
    input  logic [DATA_WIDTH-1:0] data_send,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [DATA_WIDTH-1:0] data_recv,
    output logic                  sclk,
    output logic                  mosi,
    input  logic                  miso,
    output logic [NUM_CS-1:0]     cs_n
);

    localparam int HALF = half_cycles(CLK_FREQ, SPI_FREQ);
    localparam int EW   = LW + 1;

    spi_state_t            r_state;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_err;
    logic                  r_sclk;
    logic                  r_mosi;
    logic [NUM_CS-1:0]     r_cs_n;
    logic [DATA_WIDTH-1:0] r_tx;
    logic [DATA_WIDTH-1:0] r_rx;
    logic [DATA_WIDTH-1:0] r_recv;
    logic [LW-1:0]         r_len;
    logic                  r_cpha;
    logic                  r_lsb;
    logic [EW-1:0]         r_edge;

    logic                  w_tick;
    logic                  w_idle;
    logic                  w_cs_bad;
    logic                  w_accept;
    logic [LW-1:0]         w_len;
    logic [DATA_WIDTH-1:0] w_tx_al;
    logic [DATA_WIDTH-1:0] w_tx_ld;
    logic                  w_first;
    logic                  w_bit;
    logic [DATA_WIDTH-1:0] w_tx_pop;
    logic [DATA_WIDTH-1:0] w_rx_nxt;
    logic [EW-1:0]         w_edge_nxt;
    logic [EW-1:0]         w_last;
    logic                  w_sample;
    logic                  w_shift;

    spi_clk_div #(
        .HALF (HALF)
    ) u_div (
        .clk    (clk),
        .arstn  (arstn),
        .i_clr  (w_idle),
        .i_en   (!w_idle),
        .o_tick (w_tick)
    );

    assign w_idle   = (r_state == S_IDLE);
    assign w_cs_bad = (32'(cs_sel) >= 32'(NUM_CS));
    assign w_accept = w_idle && start && !r_done && !w_cs_bad;

    assign w_len = (len == '0 || 32'(len) > DATA_WIDTH)
                 ? LW'(DATA_WIDTH) : len;

    // MSB-first words are left-aligned so the shift-out bit is always the MSB
    assign w_tx_al = lsb_first ? data_send
                               : data_send << (DATA_WIDTH - 32'(w_len));
    assign w_first = lsb_first ? w_tx_al[0] : w_tx_al[DATA_WIDTH-1];
    assign w_tx_ld = cpha ? w_tx_al
                          : (lsb_first ? w_tx_al >> 1 : w_tx_al << 1);

    assign w_bit    = r_lsb ? r_tx[0] : r_tx[DATA_WIDTH-1];
    assign w_tx_pop = r_lsb ? r_tx >> 1 : r_tx << 1;
    assign w_rx_nxt = r_lsb
                    ? ((r_rx >> 1) | (DATA_WIDTH'(miso) << (r_len - 1'b1)))
                    : {r_rx[DATA_WIDTH-2:0], miso};

    // Edge numbers run 1..2*len; parity picks sample vs shift per CPHA
    assign w_edge_nxt = r_edge + 1'b1;
    assign w_last     = {r_len, 1'b0};
    assign w_sample   = r_cpha ? ~w_edge_nxt[0] : w_edge_nxt[0];
    assign w_shift    = r_cpha ? w_edge_nxt[0]
                               : (~w_edge_nxt[0] && (w_edge_nxt != w_last));

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_sclk  <= 1'b0;
            r_mosi  <= 1'b0;
            r_cs_n  <= '1;
            r_tx    <= '0;
            r_rx    <= '0;
            r_recv  <= '0;
            r_len   <= '0;
            r_cpha  <= 1'b0;
            r_lsb   <= 1'b0;
            r_edge  <= '0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (start && !r_done && w_cs_bad) begin
                        r_err <= 1'b1;
                    end
                    if (w_accept) begin
                        r_state <= S_LEAD;
                        r_busy  <= 1'b1;
                        r_cs_n  <= ~(NUM_CS'(1) << cs_sel);
                        r_sclk  <= cpol;
                        r_len   <= w_len;
                        r_cpha  <= cpha;
                        r_lsb   <= lsb_first;
                        r_edge  <= '0;
                        r_rx    <= '0;
                        r_tx    <= w_tx_ld;
                        r_mosi  <= cpha ? 1'b0 : w_first;
                    end
                end
                S_LEAD, S_XFER: begin
                    if (w_tick) begin
                        r_sclk  <= ~r_sclk;
                        r_edge  <= w_edge_nxt;
                        r_state <= (w_edge_nxt == w_last) ? S_TRAIL : S_XFER;
                        if (w_sample) begin
                            r_rx <= w_rx_nxt;
                        end
                        if (w_shift) begin
                            r_mosi <= w_bit;
                            r_tx   <= w_tx_pop;
                        end
                    end
                end
                S_TRAIL: begin
                    if (w_tick) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_cs_n  <= '1;
                        r_recv  <= r_rx;
                        r_mosi  <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;
    assign data_recv = r_recv;
    assign sclk      = r_sclk;
    assign mosi      = r_mosi;
    assign cs_n      = r_cs_n;

endmodule

// File: tb/tb_spi_master_mc.sv
// Directed bench for spi_master_mc: loopback and slave-model transfers,
// with a scoreboard of expected words and completion cycles.
module tb_spi_master_mc;

    // Three slaves keep cs_sel at 2 bits while leaving index 3 out of range
    localparam int NCS = 3;
    localparam int DW  = 8;
    localparam logic [7:0] SLV_DATA = 8'hCD;

    typedef struct {
        string      tag;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          arstn;
    logic          start;
    logic [1:0]    cs_sel;
    logic          cpol;
    logic          cpha;
    logic          lsb_first;
    logic [3:0]    len;
    logic [DW-1:0] data_send;
    logic          busy;
    logic          done;
    logic          err;
    logic [DW-1:0] data_recv;
    logic          sclk;
    logic          mosi;
    logic          miso_w;
    logic [NCS-1:0] cs_n;

    logic       loop;
    logic       slv_miso;
    int         slv_i;
    logic [7:0] slv_rx;

    int   cyc = 0;
    int   t0 = 0;
    int   checks = 0;
    int   errors = 0;
    int   n_done = 0;
    exp_t q[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign miso_w = loop ? mosi : slv_miso;

    spi_master_mc #(
        .CLK_FREQ   (50_000_000),
        .SPI_FREQ   (5_000_000),
        .DATA_WIDTH (DW),
        .NUM_CS     (NCS)
    ) dut (
        .clk       (clk),
        .arstn     (arstn),
        .start     (start),
        .cs_sel    (cs_sel),
        .cpol      (cpol),
        .cpha      (cpha),
        .lsb_first (lsb_first),
        .len       (len),
        .data_send (data_send),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .data_recv (data_recv),
        .sclk      (sclk),
        .mosi      (mosi),
        .miso      (miso_w),
        .cs_n      (cs_n)
    );

    // Mode-3 slave on cs 2: drive on falling SCLK, capture on rising
    always @(negedge sclk or posedge cs_n[2]) begin
        if (cs_n[2]) begin
            slv_i <= 0;
        end else begin
            slv_miso <= SLV_DATA[7 - slv_i];
            slv_i    <= slv_i + 1;
        end
    end

    always @(posedge sclk) begin
        if (!cs_n[2]) slv_rx <= {slv_rx[6:0], mosi};
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (arstn === 1'b1 && done === 1'b1) begin
            n_done++;
            chk("sb_pending", 32'(q.size() > 0), 1);
            if (q.size() > 0) begin
                mon_e = q.pop_front();
                chk({mon_e.tag, "_recv"}, 32'(data_recv), 32'(mon_e.data));
                chk({mon_e.tag, "_cycle"}, cyc, mon_e.cyc);
            end
        end
    end

    task automatic go(input int cs, input logic pl, input logic ph,
                      input logic lsb, input int ln, input logic [7:0] d,
                      input logic [7:0] ex, input int lat, input string tag);
        exp_t e;
        cs_sel    = cs[1:0];
        cpol      = pl;
        cpha      = ph;
        lsb_first = lsb;
        len       = ln[3:0];
        data_send = d;
        start     = 1'b1;
        t0        = cyc;
        e.tag     = tag;
        e.data    = ex;
        e.cyc     = t0 + lat;
        q.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic to_rel(input int r);
        while (cyc - t0 < r) @(negedge clk);
    endtask

    task automatic wait_done(input string tag, input int max);
        int n = 0;
        while (done !== 1'b1 && n < max) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_finished"}, 32'(done), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        logic [7:0] pat;
        arstn = 1'b0; start = 1'b0; cs_sel = '0; cpol = 1'b0; cpha = 1'b0;
        lsb_first = 1'b0; len = '0; data_send = '0; loop = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_recv", 32'(data_recv), 0);
        chk("rst_sclk", 32'(sclk), 0);
        chk("rst_mosi", 32'(mosi), 0);
        chk("rst_cs_n", 32'(cs_n), 32'h7);
        arstn = 1'b1;
        @(negedge clk);

        // mode 0, MSB-first loopback, stray start mid-transfer
        go(0, 0, 0, 0, 8, 8'hAB, 8'hAB, 86, "t1");
        chk("t1_busy", 32'(busy), 1);
        chk("t1_cs_n", 32'(cs_n), 32'h6);
        chk("t1_mosi_first", 32'(mosi), 1);
        to_rel(30);
        cs_sel = 2'd2; data_send = 8'h00; cpol = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("t1_stray_err", 32'(err), 0);
        chk("t1_stray_cs_n", 32'(cs_n), 32'h6);
        wait_done("t1", 120);
        @(negedge clk);
        chk("t1_done_pulse", 32'(done), 0);
        chk("t1_busy_low", 32'(busy), 0);
        chk("t1_cs_release", 32'(cs_n), 32'h7);
        chk("t1_mosi_idle", 32'(mosi), 0);

        // mode 3 against the slave model on cs 2
        loop = 1'b0;
        go(2, 1, 1, 0, 8, 8'h5A, SLV_DATA, 86, "t2");
        chk("t2_sclk_lead", 32'(sclk), 1);
        chk("t2_cs_n", 32'(cs_n), 32'h3);
        wait_done("t2", 120);
        chk("t2_slave_rx", 32'(slv_rx), 32'h5A);
        @(negedge clk);
        chk("t2_sclk_idle", 32'(sclk), 1);

        // 5-bit LSB-first loopback
        loop = 1'b1;
        pat  = 8'h13;
        go(1, 0, 0, 1, 5, pat, 8'h13, 56, "t3");
        for (int i = 0; i < 5; i++) begin
            to_rel(1 + 5 * (2 * i + 1));
            chk("t3_mosi_bit", 32'(mosi), 32'(pat[i]));
        end
        wait_done("t3", 80);
        @(negedge clk);

        // out-of-range chip select is rejected
        cs_sel = 2'd3; cpol = 1'b0; start = 1'b1; t0 = cyc;
        @(negedge clk);
        start = 1'b0;
        chk("t4_err", 32'(err), 1);
        chk("t4_busy", 32'(busy), 0);
        chk("t4_cs_n", 32'(cs_n), 32'h7);
        @(negedge clk);
        chk("t4_err_once", 32'(err), 0);
        chk("t4_busy_idle", 32'(busy), 0);

        // reset mid-transfer, then a mode-1 transfer
        go(0, 0, 0, 0, 8, 8'hFF, 8'hFF, 86, "t5x");
        to_rel(40);
        arstn = 1'b0;
        #1;
        q.delete();
        chk("t5_rst_busy", 32'(busy), 0);
        chk("t5_rst_sclk", 32'(sclk), 0);
        chk("t5_rst_mosi", 32'(mosi), 0);
        chk("t5_rst_cs_n", 32'(cs_n), 32'h7);
        chk("t5_rst_recv", 32'(data_recv), 0);
        @(negedge clk);
        arstn = 1'b1;
        @(negedge clk);
        go(1, 0, 1, 0, 8, 8'h3C, 8'h3C, 86, "t5");
        wait_done("t5", 120);
        @(negedge clk);

        // back-to-back: start held through the done cycle
        go(0, 0, 0, 0, 8, 8'h96, 8'h96, 86, "t6a");
        to_rel(85);
        chk("t6_cs_a", 32'(cs_n), 32'h6);
        wait_done("t6a", 120);
        chk("t6_gap0", 32'(cs_n), 32'h7);
        cs_sel = 2'd1; data_send = 8'h69; start = 1'b1;
        @(negedge clk);
        t0 = cyc;
        mon_e.tag = "t6b"; mon_e.data = 8'h69; mon_e.cyc = t0 + 86;
        q.push_back(mon_e);
        chk("t6_gap1", 32'(cs_n), 32'h7);
        @(negedge clk);
        start = 1'b0;
        chk("t6_cs_b", 32'(cs_n), 32'h5);
        chk("t6_busy_b", 32'(busy), 1);
        wait_done("t6b", 120);
        @(negedge clk);

        chk("done_count", n_done, 6);
        chk("sb_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
